// File: rtl/mem_ctrl_pkg.sv
// Shared types, size codes and load-extension helper for the memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  // Access size codes carried in precise[1:0].
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // A fetch behaves as an unsigned word load.
  localparam logic [2:0] PRECISE_FETCH = {1'b1, SZ_W};

  // Number of byte cycles for a size code; the unused code 3 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Sign- or zero-extend a little-endian load result according to funct3.
  function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] precise);
    case (precise[1:0])
      SZ_B:    return precise[2] ? {24'h0, data[7:0]} : {{24{data[7]}}, data[7:0]};
      SZ_H:    return precise[2] ? {16'h0, data[15:0]} : {{16{data[15]}}, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller arbitrating LSB and instruction fetch onto one RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_config,
  input  logic        lsb_in_config,
  input  logic        lsb_in_ls,
  input  logic [31:0] lsb_in_addr,
  input  logic [31:0] lsb_in_data,
  input  logic [2:0]  lsb_in_precise,
  output logic        lsb_out_config,
  output logic [31:0] lsb_out_data,
  input  logic        ifetch_in_config,
  input  logic [31:0] ifetch_in_addr,
  output logic        ifetch_out_config,
  output logic [31:0] ifetch_out_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;   // bytes issued to the RAM
  logic [2:0]  cap_q, cap_d;   // READ edges taken; byte cap-1 is captured on each
  logic [31:0] buf_q, buf_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic [2:0]  req_prec_q, req_prec_d;
  logic        req_fetch_q, req_fetch_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] lsb_data_q, lsb_data_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;

  logic        store_blocked, idle_go, lsb_accept, if_accept;
  logic [2:0]  req_n;
  logic [1:0]  cap_sel;
  logic [31:0] rd_word;

  // Request arbitration: LSB has priority, a blocked IO store also stalls fetch.
  always_comb begin
    store_blocked = lsb_in_config && !lsb_in_ls && (lsb_in_addr >= IO_BASE) && io_buffer_full;
    idle_go       = (state_q == StIdle) && !rollback_config;
    lsb_accept    = idle_go && lsb_in_config && !store_blocked;
    if_accept     = idle_go && !lsb_in_config && ifetch_in_config;
    req_n         = size_bytes(req_prec_q[1:0]);
    cap_sel       = cap_q[1:0] - 2'd1;
    rd_word       = buf_q;
    rd_word[{cap_sel, 3'b000} +: 8] = mem_din;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (lsb_accept)     state_d = lsb_in_ls ? StRead : StWrite;
        else if (if_accept) state_d = StRead;
      end
      StRead: begin
        if (rollback_config)     state_d = StIdle;
        else if (cap_q == req_n) state_d = StDone;
      end
      StWrite: begin
        if (idx_q == req_n) state_d = StDone;
      end
      StDone:  state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    idx_d       = idx_q;
    cap_d       = cap_q;
    buf_d       = buf_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_prec_d  = req_prec_q;
    req_fetch_d = req_fetch_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    lsb_done_d  = 1'b0;
    lsb_data_d  = lsb_data_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    unique case (state_q)
      StIdle: begin
        if (rollback_config) begin
          mem_a_d = '0;
        end else if (lsb_accept) begin
          req_addr_d  = lsb_in_addr;
          req_data_d  = lsb_in_data;
          req_prec_d  = lsb_in_precise;
          req_fetch_d = 1'b0;
          mem_a_d     = lsb_in_addr;
          idx_d       = 3'd1;
          cap_d       = 3'd0;
          buf_d       = '0;
          mem_wr_d    = !lsb_in_ls;
          if (!lsb_in_ls) mem_dout_d = lsb_in_data[7:0];
        end else if (if_accept) begin
          req_addr_d  = ifetch_in_addr;
          req_prec_d  = PRECISE_FETCH;
          req_fetch_d = 1'b1;
          mem_a_d     = ifetch_in_addr;
          idx_d       = 3'd1;
          cap_d       = 3'd0;
          buf_d       = '0;
          mem_wr_d    = 1'b0;
        end
      end
      StRead: begin
        if (rollback_config) begin
          mem_a_d = '0;
          buf_d   = '0;
        end else begin
          if (idx_q < req_n) begin
            mem_a_d = req_addr_q + {29'd0, idx_q};
            idx_d   = idx_q + 3'd1;
          end
          cap_d = cap_q + 3'd1;
          // The first READ edge only waits out the RAM's one-cycle read latency.
          if (cap_q != 3'd0) buf_d = rd_word;
          if (cap_q == req_n) begin
            mem_a_d = '0;
            if (req_fetch_q) begin
              if_done_d = 1'b1;
              if_data_d = rd_word;
            end else begin
              lsb_done_d = 1'b1;
              lsb_data_d = extend(rd_word, req_prec_q);
            end
          end
        end
      end
      StWrite: begin
        if (idx_q < req_n) begin
          mem_a_d    = req_addr_q + {29'd0, idx_q};
          mem_dout_d = req_data_q[{idx_q[1:0], 3'b000} +: 8];
          idx_d      = idx_q + 3'd1;
        end else begin
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          lsb_done_d = 1'b1;
        end
      end
      StDone: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      cap_q       <= '0;
      buf_q       <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_prec_q  <= '0;
      req_fetch_q <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      lsb_done_q  <= 1'b0;
      lsb_data_q  <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
    end else if (rdy) begin
      idx_q       <= idx_d;
      cap_q       <= cap_d;
      buf_q       <= buf_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_prec_q  <= req_prec_d;
      req_fetch_q <= req_fetch_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      lsb_done_q  <= lsb_done_d;
      lsb_data_q  <= lsb_data_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
    end
  end

  assign mem_a             = mem_a_q;
  assign mem_dout          = mem_dout_q;
  assign mem_wr            = mem_wr_q;
  assign lsb_out_config    = lsb_done_q;
  assign lsb_out_data      = lsb_data_q;
  assign ifetch_out_config = if_done_q;
  assign ifetch_out_data   = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl with a behavioural byte RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback_config = 1'b0;
  logic        lsb_in_config = 1'b0;
  logic        lsb_in_ls = 1'b0;
  logic [31:0] lsb_in_addr = '0;
  logic [31:0] lsb_in_data = '0;
  logic [2:0]  lsb_in_precise = '0;
  logic        lsb_out_config;
  logic [31:0] lsb_out_data;
  logic        ifetch_in_config = 1'b0;
  logic [31:0] ifetch_in_addr = '0;
  logic        ifetch_out_config;
  logic [31:0] ifetch_out_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int io_writes = 0;

  mem_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .rollback_config   (rollback_config),
    .lsb_in_config     (lsb_in_config),
    .lsb_in_ls         (lsb_in_ls),
    .lsb_in_addr       (lsb_in_addr),
    .lsb_in_data       (lsb_in_data),
    .lsb_in_precise    (lsb_in_precise),
    .lsb_out_config    (lsb_out_config),
    .lsb_out_data      (lsb_out_data),
    .ifetch_in_config  (ifetch_in_config),
    .ifetch_in_addr    (ifetch_in_addr),
    .ifetch_out_config (ifetch_out_config),
    .ifetch_out_data   (ifetch_out_data),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  always #5 clk = ~clk;

  // Byte RAM: read data appears the cycle after the address; contents preloaded in reset.
  logic [7:0] ram [4096];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h000] <= 8'h93; ram[12'h001] <= 8'h00; ram[12'h002] <= 8'h50; ram[12'h003] <= 8'h00;
      ram[12'h010] <= 8'h01; ram[12'h011] <= 8'h02; ram[12'h012] <= 8'h03; ram[12'h013] <= 8'h04;
      ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
      ram[12'h104] <= 8'h80; ram[12'h105] <= 8'hFF;
      mem_din <= 8'h00;
    end else if (rdy) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  always @(posedge clk) begin
    if (!rst && rdy && mem_wr && mem_a == 32'h0003_0000) io_writes <= io_writes + 1;
  end

  typedef struct {
    logic        ls;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  prec;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Issue one LSB request and follow it to its done pulse.
  task automatic do_lsb(input vec_t v, input string tag);
    int n, lat, wr_cnt;
    logic seen;
    n = (v.prec[1:0] == 2'd0) ? 1 : (v.prec[1:0] == 2'd1) ? 2 : 4;
    lsb_in_config  = 1'b1;
    lsb_in_ls      = v.ls;
    lsb_in_addr    = v.addr;
    lsb_in_data    = v.data;
    lsb_in_precise = v.prec;
    step();
    lat = 0; wr_cnt = 0; seen = 1'b0;
    for (int s = 0; s < 20 && !seen; s++) begin
      if (s < n) begin
        chk($sformatf("%s addr%0d", tag, s), mem_a, v.addr + 32'(s));
        if (!v.ls) chk($sformatf("%s dout%0d", tag, s), {24'h0, mem_dout}, {24'h0, 8'(v.data >> (8 * s))});
      end
      if (mem_wr) wr_cnt++;
      step();
      lat = s + 1;
      if (lsb_out_config) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " wr_cycles"}, 32'(wr_cnt), v.ls ? 32'd0 : 32'(n));
    chk({tag, " addr_done"}, mem_a, 32'h0);
    chk({tag, " wr_done"}, {31'h0, mem_wr}, 32'h0);
    if (v.ls) chk({tag, " data"}, lsb_out_data, v.exp_data);
    lsb_in_config = 1'b0;
    step();
    chk({tag, " pulse_clear"}, {31'h0, lsb_out_config}, 32'h0);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0]  = '{1'b1, 32'h100, 32'h0,         3'b010, 32'h44332211, 5};
    vecs[1]  = '{1'b1, 32'h104, 32'h0,         3'b000, 32'hFFFFFF80, 2};
    vecs[2]  = '{1'b1, 32'h104, 32'h0,         3'b100, 32'h00000080, 2};
    vecs[3]  = '{1'b1, 32'h104, 32'h0,         3'b001, 32'hFFFFFF80, 3};
    vecs[4]  = '{1'b1, 32'h104, 32'h0,         3'b101, 32'h0000FF80, 3};
    vecs[5]  = '{1'b0, 32'h200, 32'hDEADBEEF,  3'b001, 32'h0,        2};
    vecs[6]  = '{1'b1, 32'h200, 32'h0,         3'b101, 32'h0000BEEF, 3};
    vecs[7]  = '{1'b1, 32'h202, 32'h0,         3'b100, 32'h00000000, 2};
    vecs[8]  = '{1'b0, 32'h204, 32'h12345678,  3'b010, 32'h0,        4};
    vecs[9]  = '{1'b1, 32'h204, 32'h0,         3'b010, 32'h12345678, 5};
    vecs[10] = '{1'b1, 32'h103, 32'h0,         3'b000, 32'h00000044, 2};

    // Reset state
    step(); step();
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst lsb_out", {31'h0, lsb_out_config}, 32'h0);
    chk("rst lsb_data", lsb_out_data, 32'h0);
    chk("rst if_out", {31'h0, ifetch_out_config}, 32'h0);
    chk("rst if_data", ifetch_out_data, 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) do_lsb(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous fetch and load: LSB first, fetch only after DONE
    ifetch_in_config = 1'b1; ifetch_in_addr = 32'h0;
    lsb_in_config = 1'b1; lsb_in_ls = 1'b1; lsb_in_addr = 32'h10; lsb_in_precise = 3'b010;
    step();
    chk("arb lsb_first", mem_a, 32'h10);
    lat = 0; seen = 1'b0;
    for (int s = 0; s < 20 && !seen; s++) begin
      step(); lat = s + 1;
      if (lsb_out_config) seen = 1'b1;
    end
    chk("arb lw_latency", 32'(lat), 32'd5);
    chk("arb lw_data", lsb_out_data, 32'h04030201);
    lsb_in_config = 1'b0;
    lat = 0; seen = 1'b0;
    for (int s = 0; s < 20 && !seen; s++) begin
      step(); lat = s + 1;
      if (s == 0) chk("arb no_accept_in_done", {31'h0, ifetch_out_config}, 32'h0);
      if (ifetch_out_config) seen = 1'b1;
    end
    chk("arb fetch_latency", 32'(lat), 32'd7);
    chk("arb fetch_data", ifetch_out_data, 32'h00500093);
    ifetch_in_config = 1'b0;
    step();

    // Rollback on the second READ cycle of a fetch
    ifetch_in_config = 1'b1; ifetch_in_addr = 32'h100;
    step();
    chk("rbf addr0", mem_a, 32'h100);
    step();
    chk("rbf addr1", mem_a, 32'h101);
    rollback_config = 1'b1;
    step();
    rollback_config = 1'b0; ifetch_in_config = 1'b0;
    chk("rbf mem_a_zero", mem_a, 32'h0);
    seen = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (ifetch_out_config) seen = 1'b1;
      step();
    end
    chk("rbf no_pulse", {31'h0, seen}, 32'h0);
    do_lsb(vecs[0], "rbf after");

    // Rollback in IDLE suppresses acceptance
    lsb_in_config = 1'b1; lsb_in_ls = 1'b1; lsb_in_addr = 32'h104; lsb_in_precise = 3'b000;
    rollback_config = 1'b1;
    step();
    rollback_config = 1'b0;
    chk("rbi no_accept", mem_a, 32'h0);
    do_lsb(vecs[1], "rbi after");

    // Rollback on the second WRITE cycle of a word store is ignored
    lsb_in_config = 1'b1; lsb_in_ls = 1'b0; lsb_in_addr = 32'h300;
    lsb_in_data = 32'hA1B2C3D4; lsb_in_precise = 3'b010;
    step(); step();
    rollback_config = 1'b1;
    step();
    rollback_config = 1'b0;
    lat = 2; seen = lsb_out_config;
    for (int s = 0; s < 20 && !seen; s++) begin
      step(); lat++;
      if (lsb_out_config) seen = 1'b1;
    end
    chk("rbw latency", 32'(lat), 32'd4);
    lsb_in_config = 1'b0;
    step();
    do_lsb('{1'b1, 32'h300, 32'h0, 3'b010, 32'hA1B2C3D4, 5}, "rbw readback");

    // IO store held off by a full buffer, fetch also stalled
    io_buffer_full = 1'b1;
    ifetch_in_config = 1'b1; ifetch_in_addr = 32'h8;
    lsb_in_config = 1'b1; lsb_in_ls = 1'b0; lsb_in_addr = 32'h0003_0000;
    lsb_in_data = 32'h0000005A; lsb_in_precise = 3'b000;
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("io blocked_wr%0d", s), {31'h0, mem_wr}, 32'h0);
      chk($sformatf("io blocked_a%0d", s), mem_a, 32'h0);
    end
    io_buffer_full = 1'b0;
    step();
    chk("io wr", {31'h0, mem_wr}, 32'h1);
    chk("io addr", mem_a, 32'h0003_0000);
    chk("io dout", {24'h0, mem_dout}, 32'h5A);
    step();
    chk("io done", {31'h0, lsb_out_config}, 32'h1);
    lsb_in_config = 1'b0; ifetch_in_config = 1'b0;
    step();
    chk("io single_write", 32'(io_writes), 32'd1);

    // Asynchronous reset in the middle of a word store
    lsb_in_config = 1'b1; lsb_in_ls = 1'b0; lsb_in_addr = 32'h340;
    lsb_in_data = 32'h11223344; lsb_in_precise = 3'b010;
    step(); step();
    chk("arst wr_before", {31'h0, mem_wr}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst wr_dropped", {31'h0, mem_wr}, 32'h0);
    chk("arst addr", mem_a, 32'h0);
    lsb_in_config = 1'b0;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      if (lsb_out_config) seen = 1'b1;
    end
    chk("arst no_pulse", {31'h0, seen}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
